// File: rtl/multiplication_accum_pipe.sv
// Pipelined outer-product multiply-accumulate: DIM_C x DIM_A products per beat, summed
// over programmable-length groups with signed/unsigned operands and saturate/wrap overflow.
module multiplication_accum_pipe #(
  parameter int DIM_A        = 4,
  parameter int DIM_C        = 2,
  parameter int INPUT_WIDTH  = 4,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 16,
  parameter int MUL_STAGES   = 2,
  parameter int LEN_WIDTH    = 4,
  parameter int SAT          = 1
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [DIM_A-1:0][INPUT_WIDTH-1:0]               in,
  input  logic [DIM_C-1:0][WEIGHT_WIDTH-1:0]              weight,
  input  logic                                            signed_mode,
  input  logic [LEN_WIDTH-1:0]                            acc_len,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0]      out,
  output logic                                            out_ovf
);

  localparam int  PW     = INPUT_WIDTH + WEIGHT_WIDTH;
  localparam int  EW     = ACC_WIDTH + 1;
  localparam bit  SAT_EN = (SAT != 0);

  typedef logic [DIM_C-1:0][DIM_A-1:0][PW-1:0] prod_t;

  // Both operands are widened to the full product width so one multiplier serves both modes.
  function automatic logic [PW-1:0] mul_elem(input logic [INPUT_WIDTH-1:0] a,
                                             input logic [WEIGHT_WIDTH-1:0] b,
                                             input logic sm);
    logic [PW-1:0] ae;
    logic [PW-1:0] be;
    ae = sm ? {{WEIGHT_WIDTH{a[INPUT_WIDTH-1]}}, a} : {{WEIGHT_WIDTH{1'b0}}, a};
    be = sm ? {{INPUT_WIDTH{b[WEIGHT_WIDTH-1]}}, b} : {{INPUT_WIDTH{1'b0}}, b};
    return ae * be;
  endfunction

  logic                    en_s;
  logic                    accept_s;
  logic                    first_s;
  logic                    last_s;
  logic [LEN_WIDTH-1:0]    eff_len_s;
  logic [LEN_WIDTH-1:0]    cnt_r;
  logic [LEN_WIDTH-1:0]    len_r;

  logic                                       s0_valid_r;
  logic                                       s0_first_r;
  logic                                       s0_last_r;
  logic                                       s0_signed_r;
  logic [DIM_A-1:0][INPUT_WIDTH-1:0]          s0_in_r;
  logic [DIM_C-1:0][WEIGHT_WIDTH-1:0]         s0_w_r;

  prod_t                    prod_s;
  prod_t                    p_prod_r [MUL_STAGES];
  logic [MUL_STAGES-1:0]    p_valid_r;
  logic [MUL_STAGES-1:0]    p_first_r;
  logic [MUL_STAGES-1:0]    p_last_r;
  logic [MUL_STAGES-1:0]    p_signed_r;

  logic                                       tl_valid_s;
  logic                                       tl_first_s;
  logic                                       tl_last_s;
  logic                                       tl_signed_s;
  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] acc_r;
  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] acc_nxt_s;
  logic                                       ovf_r;
  logic                                       ovf_nxt_s;
  logic                                       ovf_any_s;
  logic                                       out_valid_r;

  assign en_s      = !(out_valid_r && !out_ready);
  assign in_ready  = en_s;
  assign accept_s  = in_valid && en_s;
  assign out_valid = out_valid_r;
  assign out       = acc_r;
  assign out_ovf   = ovf_r;

  // Group position of the incoming beat; a zero length counts as a single-beat group.
  always_comb begin
    first_s = (cnt_r == {LEN_WIDTH{1'b0}});
    if (first_s) begin
      eff_len_s = (acc_len == {LEN_WIDTH{1'b0}}) ? LEN_WIDTH'(1) : acc_len;
    end else begin
      eff_len_s = len_r;
    end
    last_s = (cnt_r == (eff_len_s - LEN_WIDTH'(1)));
  end

  // Beat counter and group length latched on the first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {LEN_WIDTH{1'b0}};
      len_r <= {LEN_WIDTH{1'b0}};
    end else if (accept_s) begin
      cnt_r <= last_s ? {LEN_WIDTH{1'b0}} : (cnt_r + LEN_WIDTH'(1));
      if (first_s) begin
        len_r <= eff_len_s;
      end
    end
  end

  // Input register with the tags that travel alongside the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_r  <= 1'b0;
      s0_first_r  <= 1'b0;
      s0_last_r   <= 1'b0;
      s0_signed_r <= 1'b0;
      s0_in_r     <= '0;
      s0_w_r      <= '0;
    end else if (en_s) begin
      s0_valid_r  <= in_valid;
      s0_first_r  <= first_s;
      s0_last_r   <= last_s;
      s0_signed_r <= signed_mode;
      s0_in_r     <= in;
      s0_w_r      <= weight;
    end
  end

  // Outer product of the registered operands.
  always_comb begin
    prod_s = '0;
    for (int c = 0; c < DIM_C; c++) begin
      for (int a = 0; a < DIM_A; a++) begin
        prod_s[c][a] = mul_elem(s0_in_r[a], s0_w_r[c], s0_signed_r);
      end
    end
  end

  // Multiplier register chain; the whole chain freezes under output backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_r  <= '0;
      p_first_r  <= '0;
      p_last_r   <= '0;
      p_signed_r <= '0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        p_prod_r[i] <= '0;
      end
    end else if (en_s) begin
      p_valid_r[0]  <= s0_valid_r;
      p_first_r[0]  <= s0_first_r;
      p_last_r[0]   <= s0_last_r;
      p_signed_r[0] <= s0_signed_r;
      p_prod_r[0]   <= prod_s;
      for (int i = 1; i < MUL_STAGES; i++) begin
        p_valid_r[i]  <= p_valid_r[i-1];
        p_first_r[i]  <= p_first_r[i-1];
        p_last_r[i]   <= p_last_r[i-1];
        p_signed_r[i] <= p_signed_r[i-1];
        p_prod_r[i]   <= p_prod_r[i-1];
      end
    end
  end

  assign tl_valid_s  = p_valid_r[MUL_STAGES-1];
  assign tl_first_s  = p_first_r[MUL_STAGES-1];
  assign tl_last_s   = p_last_r[MUL_STAGES-1];
  assign tl_signed_s = p_signed_r[MUL_STAGES-1];

  // Accumulate with one guard bit; the overflow test follows the mode of the arriving beat.
  always_comb begin
    logic [EW-1:0] pe_v;
    logic [EW-1:0] ae_v;
    logic [EW-1:0] sum_v;
    logic          lov_v;
    pe_v      = '0;
    ae_v      = '0;
    sum_v     = '0;
    lov_v     = 1'b0;
    acc_nxt_s = acc_r;
    ovf_any_s = 1'b0;
    for (int c = 0; c < DIM_C; c++) begin
      for (int a = 0; a < DIM_A; a++) begin
        if (tl_signed_s) begin
          pe_v  = {{(EW-PW){p_prod_r[MUL_STAGES-1][c][a][PW-1]}}, p_prod_r[MUL_STAGES-1][c][a]};
          ae_v  = {acc_r[c][a][ACC_WIDTH-1], acc_r[c][a]};
          sum_v = ae_v + pe_v;
          lov_v = sum_v[EW-1] ^ sum_v[EW-2];
        end else begin
          pe_v  = {{(EW-PW){1'b0}}, p_prod_r[MUL_STAGES-1][c][a]};
          ae_v  = {1'b0, acc_r[c][a]};
          sum_v = ae_v + pe_v;
          lov_v = sum_v[EW-1];
        end
        if (tl_first_s) begin
          acc_nxt_s[c][a] = pe_v[ACC_WIDTH-1:0];
        end else if (lov_v && SAT_EN) begin
          if (!tl_signed_s) begin
            acc_nxt_s[c][a] = {ACC_WIDTH{1'b1}};
          end else if (sum_v[EW-1]) begin
            acc_nxt_s[c][a] = {1'b1, {(ACC_WIDTH-1){1'b0}}};
          end else begin
            acc_nxt_s[c][a] = {1'b0, {(ACC_WIDTH-1){1'b1}}};
          end
        end else begin
          acc_nxt_s[c][a] = sum_v[ACC_WIDTH-1:0];
        end
        if (!tl_first_s && lov_v) begin
          ovf_any_s = 1'b1;
        end else begin
          ovf_any_s = ovf_any_s;
        end
      end
    end
    ovf_nxt_s = (tl_first_s ? 1'b0 : ovf_r) | ovf_any_s;
  end

  // Accumulator, sticky overflow and result-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= '0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (en_s) begin
      out_valid_r <= tl_valid_s && tl_last_s;
      if (tl_valid_s) begin
        acc_r <= acc_nxt_s;
        ovf_r <= ovf_nxt_s;
      end
    end
  end

endmodule
